// File: rtl/prl_pkg.sv
// rtl/prl_pkg.sv - shared types and helpers for the pixel-region trigger buffer
// Entry state encoding, overflow counter width and hit-word width helper.
package prl_pkg;

  typedef enum logic [1:0] {
    ENTRY_FREE = 2'd0,
    ENTRY_WAIT = 2'd1,
    ENTRY_TRIG = 2'd2
  } entry_state_e;

  localparam int OVF_CNT_BITS = 8;

  function automatic int word_bits(input int npix, input int tot_bits);
    return npix * (1 + tot_bits);
  endfunction

endpackage

// File: rtl/prl_entry.sv
// rtl/prl_entry.sv - one buffer slot: hit word, latency countdown and trigger ID
// Holds a word through its latency window, keeps it on a coincident L1, frees it on read.
module prl_entry
  import prl_pkg::*;
#(
  parameter int LAT_BITS  = 9,
  parameter int TID_BITS  = 5,
  parameter int WORD_BITS = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 alloc_i,
  input  logic [WORD_BITS-1:0] word_i,
  input  logic [LAT_BITS-1:0]  lat_i,
  input  logic                 trig_i,
  input  logic [TID_BITS-1:0]  trig_id_i,
  input  logic [TID_BITS-1:0]  tid_req_i,
  input  logic                 read_i,
  output logic                 free_o,
  output logic                 match_o,
  output logic [WORD_BITS-1:0] word_o
);

  localparam logic [LAT_BITS-1:0] CNT_ONE = LAT_BITS'(1);

  entry_state_e         state_q, state_d;
  logic [LAT_BITS-1:0]  cnt_q, cnt_d;
  logic [TID_BITS-1:0]  tid_q, tid_d;
  logic [WORD_BITS-1:0] word_q, word_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ENTRY_FREE;
      cnt_q   <= '0;
      tid_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tid_q   <= tid_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tid_d   = tid_q;
    word_d  = word_q;
    case (state_q)
      ENTRY_FREE: begin
        if (alloc_i) begin
          state_d = ENTRY_WAIT;
          cnt_d   = lat_i;
          word_d  = word_i;
        end
      end
      ENTRY_WAIT: begin
        // A count of 1 means this edge is the expiry edge that samples L1.
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (trig_i) begin
          state_d = ENTRY_TRIG;
          tid_d   = trig_id_i;
        end else begin
          state_d = ENTRY_FREE;
        end
      end
      ENTRY_TRIG: begin
        if (read_i) state_d = ENTRY_FREE;
      end
      default: state_d = ENTRY_FREE;
    endcase
  end

  assign free_o  = (state_q == ENTRY_FREE);
  assign match_o = (state_q == ENTRY_TRIG) && (tid_q == tid_req_i);
  assign word_o  = word_q;

endmodule

// File: rtl/pixel_region_trig_buffer.sv
// rtl/pixel_region_trig_buffer.sv - DEPTH-entry region latency/trigger buffer with token readout
// Optional dropped-write counter on OvfCnt when PRL_OVFCNT_EN is defined.
module pixel_region_trig_buffer
  import prl_pkg::*;
#(
  parameter int NPIX     = 4,
  parameter int TOT_BITS = 4,
  parameter int DEPTH    = 8,
  parameter int LAT_BITS = 9,
  parameter int TID_BITS = 5
) (
  input  logic                                   Clk,
  input  logic                                   ResetB,
  input  logic                                   Write,
  input  logic [NPIX-1:0]                        HitMap,
  input  logic [NPIX*TOT_BITS-1:0]               ToTs,
  input  logic [LAT_BITS-1:0]                    LatCnt,
  input  logic                                   L1Trig,
  input  logic [TID_BITS-1:0]                    TrigId,
  input  logic [TID_BITS-1:0]                    TrigIdReq,
  input  logic                                   Read,
  input  logic                                   TokIn,
  output logic                                   TokOut,
  output logic [word_bits(NPIX, TOT_BITS)-1:0]   DataOut,
  output logic                                   DataValid,
  output logic                                   Full
`ifdef PRL_OVFCNT_EN
  ,
  output logic [OVF_CNT_BITS-1:0]                OvfCnt
`endif
);

  localparam int WORD_BITS = word_bits(NPIX, TOT_BITS);
  localparam int IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LAT_BITS-1:0]                 lat_eff;
  logic                                hit_write;
  logic [DEPTH-1:0]                    free_vec;
  logic [DEPTH-1:0]                    match_vec;
  logic [DEPTH-1:0]                    alloc_vec;
  logic [DEPTH-1:0]                    read_vec;
  logic [DEPTH-1:0][WORD_BITS-1:0]     entry_words;
  logic [IDX_BITS-1:0]                 sel_idx;
  logic                                any_match;

  assign lat_eff   = (LatCnt == '0) ? LAT_BITS'(1) : LatCnt;
  assign hit_write = Write && (HitMap != '0);

  // Allocation and read select both pick the lowest index; the downward scan
  // lets the last assignment win.
  always_comb begin
    alloc_vec = '0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_write && free_vec[i]) begin
        alloc_vec    = '0;
        alloc_vec[i] = 1'b1;
      end
      if (match_vec[i]) sel_idx = IDX_BITS'(i);
    end
  end

  assign any_match = |match_vec;
  assign DataValid = any_match && !TokIn;
  assign DataOut   = DataValid ? entry_words[sel_idx] : '0;
  assign TokOut    = TokIn || any_match;
  assign Full      = ~|free_vec;

  always_comb begin
    read_vec = '0;
    if (Read && DataValid) read_vec[sel_idx] = 1'b1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    prl_entry #(
      .LAT_BITS (LAT_BITS),
      .TID_BITS (TID_BITS),
      .WORD_BITS(WORD_BITS)
    ) u_entry (
      .clk_i    (Clk),
      .rst_n_i  (ResetB),
      .alloc_i  (alloc_vec[g]),
      .word_i   ({HitMap, ToTs}),
      .lat_i    (lat_eff),
      .trig_i   (L1Trig),
      .trig_id_i(TrigId),
      .tid_req_i(TrigIdReq),
      .read_i   (read_vec[g]),
      .free_o   (free_vec[g]),
      .match_o  (match_vec[g]),
      .word_o   (entry_words[g])
    );
  end

`ifdef PRL_OVFCNT_EN
  logic [OVF_CNT_BITS-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (hit_write && Full && (ovf_q != '1)) ovf_d = ovf_q + OVF_CNT_BITS'(1);
  end

  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) ovf_q <= '0;
    else         ovf_q <= ovf_d;
  end

  assign OvfCnt = ovf_q;
`endif

endmodule

// File: tb/tb_pixel_region_trig_buffer.sv
// tb/tb_pixel_region_trig_buffer.sv - directed vector bench for pixel_region_trig_buffer
// Single-entry latency/trigger table plus hand-written multi-entry sequences.
module tb_pixel_region_trig_buffer;

  logic        Clk;
  logic        ResetB;
  logic        Write;
  logic [3:0]  HitMap;
  logic [15:0] ToTs;
  logic [8:0]  LatCnt;
  logic        L1Trig;
  logic [4:0]  TrigId;
  logic [4:0]  TrigIdReq;
  logic        Read;
  logic        TokIn;
  logic        TokOut;
  logic [19:0] DataOut;
  logic        DataValid;
  logic        Full;
`ifdef PRL_OVFCNT_EN
  logic [7:0]  OvfCnt;
`endif

  pixel_region_trig_buffer dut (
    .Clk      (Clk),
    .ResetB   (ResetB),
    .Write    (Write),
    .HitMap   (HitMap),
    .ToTs     (ToTs),
    .LatCnt   (LatCnt),
    .L1Trig   (L1Trig),
    .TrigId   (TrigId),
    .TrigIdReq(TrigIdReq),
    .Read     (Read),
    .TokIn    (TokIn),
    .TokOut   (TokOut),
    .DataOut  (DataOut),
    .DataValid(DataValid),
    .Full     (Full)
`ifdef PRL_OVFCNT_EN
    ,
    .OvfCnt   (OvfCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // mask bit0/1/2: L1 pulse at write edge + Leff-1 / Leff / Leff+1
  typedef struct {
    logic [8:0]  lat;
    logic [3:0]  hit;
    logic [15:0] tots;
    logic [2:0]  mask;
    logic [4:0]  tid;
    logic [4:0]  req;
    logic        tok;
    logic        exp_valid;
    logic [19:0] exp_data;
    logic        exp_tok;
  } vec_t;

  vec_t vecs[7];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Write = 1'b0; HitMap = '0; ToTs = '0; LatCnt = '0; L1Trig = 1'b0;
    TrigId = '0; TrigIdReq = '0; Read = 1'b0; TokIn = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ResetB = 1'b0;
    @(posedge Clk);
    #2;
    ResetB = 1'b1;
    #1;
  endtask

  initial begin
    int leff;
    vecs[0] = '{9'd10, 4'h5, 16'h4321, 3'b010, 5'd3,  5'd3,  1'b0, 1'b1, 20'h54321, 1'b1};
    vecs[1] = '{9'd10, 4'h5, 16'h4321, 3'b101, 5'd3,  5'd3,  1'b0, 1'b0, 20'h00000, 1'b0};
    vecs[2] = '{9'd0,  4'hA, 16'hBEEF, 3'b010, 5'd1,  5'd1,  1'b0, 1'b1, 20'hABEEF, 1'b1};
    vecs[3] = '{9'd3,  4'hF, 16'h1234, 3'b010, 5'd3,  5'd4,  1'b0, 1'b0, 20'h00000, 1'b0};
    vecs[4] = '{9'd3,  4'hF, 16'h1234, 3'b010, 5'd31, 5'd31, 1'b1, 1'b0, 20'h00000, 1'b1};
    vecs[5] = '{9'd2,  4'h0, 16'h5555, 3'b111, 5'd2,  5'd2,  1'b0, 1'b0, 20'h00000, 1'b0};
    vecs[6] = '{9'd1,  4'h8, 16'h000F, 3'b110, 5'd9,  5'd9,  1'b0, 1'b1, 20'h8000F, 1'b1};

    // Reset state
    clear_inputs();
    ResetB = 1'b0;
    #12;
    TokIn = 1'b1;
    #1;
    check("rst_tokout_tokin1", TokOut, 1);
    TokIn = 1'b0;
    #1;
    check("rst_tokout_tokin0", TokOut, 0);
    check("rst_datavalid", DataValid, 0);
    check("rst_dataout", DataOut, 0);
    check("rst_full", Full, 0);
`ifdef PRL_OVFCNT_EN
    check("rst_ovfcnt", OvfCnt, 0);
`endif

    // Single-entry table
    for (int v = 0; v < 7; v++) begin
      do_reset();
      LatCnt = vecs[v].lat;
      leff   = (vecs[v].lat == 0) ? 1 : int'(vecs[v].lat);
      for (int e = 0; e <= leff + 1; e++) begin
        Write  = (e == 0);
        HitMap = vecs[v].hit;
        ToTs   = vecs[v].tots;
        TrigId = vecs[v].tid;
        L1Trig = (vecs[v].mask[0] && e == leff - 1) ||
                 (vecs[v].mask[1] && e == leff) ||
                 (vecs[v].mask[2] && e == leff + 1);
        tick();
      end
      Write = 1'b0; L1Trig = 1'b0;
      TrigIdReq = vecs[v].req;
      TokIn = vecs[v].tok;
      #1;
      check($sformatf("vec%0d_datavalid", v), DataValid, vecs[v].exp_valid);
      check($sformatf("vec%0d_dataout", v), DataOut, vecs[v].exp_data);
      check($sformatf("vec%0d_tokout", v), TokOut, vecs[v].exp_tok);
    end

    // Fill to Full and overflow accounting
    do_reset();
    LatCnt = 9'd400;
    for (int e = 0; e < 9; e++) begin
      Write = 1'b1; HitMap = 4'h1; ToTs = 16'(e);
      tick();
      if (e == 6) check("fill_full_after7", Full, 0);
      if (e == 7) check("fill_full_after8", Full, 1);
    end
`ifdef PRL_OVFCNT_EN
    check("ovf_after_9th", OvfCnt, 1);
`endif
    for (int e = 0; e < 300; e++) tick();
    Write = 1'b0;
    #1;
    check("fill_full_hold", Full, 1);
`ifdef PRL_OVFCNT_EN
    check("ovf_saturate", OvfCnt, 255);
`endif

    // Read on the same edge as a Full write does not rescue the write
    do_reset();
    LatCnt = 9'd3; L1Trig = 1'b1; TrigId = 5'd7;
    for (int i = 0; i < 8; i++) begin
      Write = 1'b1; HitMap = 4'(i + 1); ToTs = 16'(i * 16'h1111);
      tick();
    end
    TrigIdReq = 5'd7; TokIn = 1'b0; Read = 1'b1;
    HitMap = 4'hF; ToTs = 16'hABCD;
    tick();
    check("rdfull_full_after_read", Full, 0);
    check("rdfull_next_sel", DataOut, 20'h21111);
    Read = 1'b0; HitMap = 4'h9; ToTs = 16'h9999;
    tick();
    check("rdfull_refill_full", Full, 1);
`ifdef PRL_OVFCNT_EN
    check("rdfull_ovfcnt", OvfCnt, 1);
`endif
    Write = 1'b0;
    for (int e = 0; e < 3; e++) tick();
    check("rdfull_slot0_word", DataOut, 20'h99999);

    // Two triggered IDs, token blocking, read by ID
    do_reset();
    LatCnt = 9'd2;
    Write = 1'b1; HitMap = 4'h3; ToTs = 16'h3333;
    tick();
    HitMap = 4'h5; ToTs = 16'h5555;
    tick();
    Write = 1'b0; L1Trig = 1'b1; TrigId = 5'd3;
    tick();
    TrigId = 5'd5;
    tick();
    L1Trig = 1'b0; TrigIdReq = 5'd5; TokIn = 1'b1;
    #1;
    check("tok_block_valid", DataValid, 0);
    check("tok_block_tokout", TokOut, 1);
    check("tok_block_data", DataOut, 0);
    TokIn = 1'b0;
    #1;
    check("id5_valid", DataValid, 1);
    check("id5_data", DataOut, 20'h55555);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    #1;
    check("id5_gone_valid", DataValid, 0);
    check("id5_gone_tokout", TokOut, 0);
    TrigIdReq = 5'd3;
    #1;
    check("id3_kept_valid", DataValid, 1);
    check("id3_kept_data", DataOut, 20'h33333);

    // Asynchronous reset with three triggered entries
    do_reset();
    LatCnt = 9'd1; L1Trig = 1'b1; TrigId = 5'd4;
    for (int i = 0; i < 3; i++) begin
      Write = 1'b1; HitMap = 4'(i + 1); ToTs = 16'hFFFF;
      tick();
    end
    Write = 1'b0;
    tick();
    L1Trig = 1'b0; TrigIdReq = 5'd4; TokIn = 1'b0;
    #1;
    check("pre_rst_valid", DataValid, 1);
    #1;
    ResetB = 1'b0;
    #1;
    check("async_rst_valid", DataValid, 0);
    check("async_rst_data", DataOut, 0);
    check("async_rst_tokout", TokOut, 0);
    check("async_rst_full", Full, 0);
    #2;
    ResetB = 1'b1;
    tick();
    check("post_rst_valid", DataValid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
